// File: rtl/ddr3_mem_model_pkg.sv
// ----------------------------------------------------------------------------
// ddr3_mem_model_pkg
// Shared types and constants for the DDR3 Avalon-MM slave behavioural model.
//   state_t    : burst state machine encoding
//   LFSR_SEED  : reset value of the optional random-stall LFSR
//   LFSR_TAPS  : feedback mask for x^16 + x^14 + x^13 + x^11 + 1
//   clog2()    : ceiling log2, used for the burstcount and memory index widths
// ----------------------------------------------------------------------------
package ddr3_mem_model_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Bits 15, 13, 12 and 10 correspond to the x^16, x^14, x^13, x^11 terms.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ddr3_mem_model_rd_pipe.sv
// ----------------------------------------------------------------------------
// ddr3_rd_pipe
// Fixed-depth shift register carrying {valid, data} read beats from the
// issue register to the Avalon read-return port.
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low clear of every stage
//   in_valid  : beat valid entering stage 0
//   in_data   : beat data entering stage 0
//   out_valid : valid of the last stage
//   out_data  : data of the last stage
// ----------------------------------------------------------------------------
module ddr3_rd_pipe #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data
);

    logic                     vld [DEPTH];
    logic signed [DATA_W-1:0] dat [DEPTH];

    // Reset drops every in-flight beat so nothing returns after a reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld[i] <= 1'b0;
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            dat[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/ddr3_mem_model.sv
// ----------------------------------------------------------------------------
// ddr3_mem_model
// Cycle-accurate behavioural model of a DDR3 controller Avalon-MM slave port
// with burst reads/writes, configurable read latency and waitrequest
// backpressure during read bursts.
// Optional feature macro: DDR3_MEM_MODEL_RANDOM_WAIT_EN adds LFSR-driven
// pseudo-random stalls on command and write beats.
// Ports:
//   clk               : clock, rising edge
//   reset_n           : asynchronous active-low reset
//   ddr_addr          : word address, sampled on the first beat
//   ddr_read          : read request
//   ddr_write         : write request
//   ddr_writedata     : write data, sampled on every accepted write beat
//   ddr_burstcount    : burst length, first beat only, 0 means 1
//   ddr_readdata      : read return data
//   ddr_readdatavalid : read return valid
//   ddr_waitrequest   : request not accepted this cycle (combinational)
//   ddr_err           : sticky out-of-range / protocol error flag
// ----------------------------------------------------------------------------
module ddr3_mem_model
    import ddr3_mem_model_pkg::*;
#(
    parameter int  DATA_W     = 16,
    parameter int  ADDR_W     = 16,
    parameter int  DEPTH      = 512,
    parameter int  RD_LATENCY = 1,
    parameter int  MAX_BURST  = 8,
    localparam int BURST_W    = clog2(MAX_BURST) + 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_W-1:0]        ddr_addr,
    input  logic                     ddr_read,
    input  logic                     ddr_write,
    input  logic signed [DATA_W-1:0] ddr_writedata,
    input  logic [BURST_W-1:0]       ddr_burstcount,
    output logic signed [DATA_W-1:0] ddr_readdata,
    output logic                     ddr_readdatavalid,
    output logic                     ddr_waitrequest,
    output logic                     ddr_err
);

    // Beat addresses are computed wide enough that base+i never wraps.
    localparam int WA     = ADDR_W + BURST_W;
    localparam int MEM_AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic signed [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    state_t               state, next_state;
    logic [ADDR_W-1:0]    base, next_base;
    logic [BURST_W-1:0]   idx, next_idx;
    logic [BURST_W-1:0]   remain, next_remain;
    logic [BURST_W-1:0]   eff_burst;
    logic [WA-1:0]        beat_addr;
    logic [MEM_AW-1:0]    mem_idx;
    logic                 stall;
    logic                 rd_acc;
    logic                 wr_acc;
    logic                 issue_en;
    logic                 in_range;
    logic                 issue_valid;
    logic signed [DATA_W-1:0] issue_data;

`ifdef DDR3_MEM_MODEL_RANDOM_WAIT_EN
    logic [15:0] lfsr;

    // Free-running Fibonacci LFSR; bit 0 requests a stall each cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    // Read return is never stalled, so the stall is masked in RD_BURST.
    assign stall = lfsr[0] && (state != RD_BURST);
`else
    assign stall = 1'b0;
`endif

    assign ddr_waitrequest = (state == RD_BURST)
                          || (ddr_read && ddr_write)
                          || ((state == WR_BURST) && ddr_read)
                          || stall;

    assign rd_acc    = ddr_read  && !ddr_waitrequest;
    assign wr_acc    = ddr_write && !ddr_waitrequest;
    assign eff_burst = (ddr_burstcount == '0) ? BURST_W'(1) : ddr_burstcount;

    // In IDLE the first beat uses the request address directly; later beats
    // come from the latched base plus the running beat index.
    assign beat_addr = (state == IDLE) ? WA'(ddr_addr) : (WA'(base) + WA'(idx));
    assign in_range  = 32'(beat_addr) < DEPTH;
    assign mem_idx   = beat_addr[MEM_AW-1:0];
    assign issue_en  = ((state == IDLE) && rd_acc) || (state == RD_BURST);

    // Next-state logic: remain counts beats still to go after the first one.
    always_comb begin
        next_state  = state;
        next_base   = base;
        next_idx    = idx;
        next_remain = remain;
        case (state)
            IDLE: begin
                if ((rd_acc || wr_acc) && (eff_burst > BURST_W'(1))) begin
                    next_state  = rd_acc ? RD_BURST : WR_BURST;
                    next_base   = ddr_addr;
                    next_idx    = BURST_W'(1);
                    next_remain = eff_burst - BURST_W'(1);
                end
            end
            RD_BURST: begin
                next_idx    = idx + BURST_W'(1);
                next_remain = remain - BURST_W'(1);
                if (remain == BURST_W'(1)) begin
                    next_state = IDLE;
                end
            end
            WR_BURST: begin
                if (wr_acc) begin
                    next_idx    = idx + BURST_W'(1);
                    next_remain = remain - BURST_W'(1);
                    if (remain == BURST_W'(1)) begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register; reset aborts any burst in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            base   <= '0;
            idx    <= '0;
            remain <= '0;
        end else begin
            state  <= next_state;
            base   <= next_base;
            idx    <= next_idx;
            remain <= next_remain;
        end
    end

    // Memory is deliberately not reset so completed writes survive a reset.
    always_ff @(posedge clk) begin
        if (wr_acc && in_range) begin
            mem[mem_idx] <= ddr_writedata;
        end
    end

    // Issue register samples the old memory contents, giving read-before-
    // write behaviour when a read and write hit the same word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_valid <= 1'b0;
            issue_data  <= '0;
        end else begin
            issue_valid <= issue_en;
            issue_data  <= (issue_en && in_range) ? mem[mem_idx] : '0;
        end
    end

    // Sticky error: simultaneous read/write or any out-of-range beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ddr_err <= 1'b0;
        end else if ((ddr_read && ddr_write) || ((issue_en || wr_acc) && !in_range)) begin
            ddr_err <= 1'b1;
        end
    end

    ddr3_rd_pipe #(
        .DATA_W (DATA_W),
        .DEPTH  (RD_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (issue_valid),
        .in_data   (issue_data),
        .out_valid (ddr_readdatavalid),
        .out_data  (ddr_readdata)
    );

endmodule

// File: tb/tb_ddr3_mem_model.sv
// ----------------------------------------------------------------------------
// tb_ddr3_mem_model
// Drives two ddr3_mem_model instances (RD_LATENCY 1 and 3) from the same bus
// and checks read timing, burst data, error flagging and reset abort.
// Optional feature macro: DDR3_MEM_MODEL_RANDOM_WAIT_EN enables the random
// stall section.
// ----------------------------------------------------------------------------
module tb_ddr3_mem_model;

    typedef struct {
        int     cyc;
        longint data;
    } beat_t;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [15:0]        ddr_addr;
    logic               ddr_read;
    logic               ddr_write;
    logic signed [15:0] ddr_writedata;
    logic [3:0]         ddr_burstcount;

    logic signed [15:0] rd1, rd3;
    logic               rdv1, rdv3;
    logic               wr1, wr3;
    logic               err1, err3;

    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    int     stall_cnt = 0;
    beat_t  q1[$];
    beat_t  q3[$];
    longint exp_beats [4];
    longint rand_data [200];

    ddr3_mem_model #(.RD_LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .ddr_addr(ddr_addr), .ddr_read(ddr_read),
        .ddr_write(ddr_write), .ddr_writedata(ddr_writedata), .ddr_burstcount(ddr_burstcount),
        .ddr_readdata(rd1), .ddr_readdatavalid(rdv1), .ddr_waitrequest(wr1), .ddr_err(err1)
    );

    ddr3_mem_model #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .ddr_addr(ddr_addr), .ddr_read(ddr_read),
        .ddr_write(ddr_write), .ddr_writedata(ddr_writedata), .ddr_burstcount(ddr_burstcount),
        .ddr_readdata(rd3), .ddr_readdatavalid(rdv3), .ddr_waitrequest(wr3), .ddr_err(err3)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc holds the index of the last rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Log every returned beat with the cycle it was visible in.
    always @(negedge clk) begin
        if (rdv1) q1.push_back('{cyc: cyc, data: longint'(rd1)});
        if (rdv3) q3.push_back('{cyc: cyc, data: longint'(rd3)});
    end

    // Hard time limit so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        ddr_read       = 1'b0;
        ddr_write      = 1'b0;
        ddr_addr       = '0;
        ddr_writedata  = '0;
        ddr_burstcount = '0;
    endtask

    // Present one beat and hold it until accepted; returns the accepting edge.
    // Called #1 after a rising edge and returns #1 after the accepting edge.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                                 input logic signed [15:0] wdata, input logic [3:0] bc,
                                 output int acc_edge);
        ddr_read       = rd;
        ddr_write      = wr;
        ddr_addr       = addr;
        ddr_writedata  = wdata;
        ddr_burstcount = bc;
        acc_edge = -1;
        for (int n = 0; n < 64 && acc_edge < 0; n++) begin
            @(negedge clk);
            if (!wr1) begin
                acc_edge = cyc + 1;
            end else begin
                stall_cnt++;
            end
            @(posedge clk);
            #1;
        end
        if (acc_edge < 0) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic do_reset();
        bus_idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Compare logged beats of both instances against exp_beats[0..n-1].
    task automatic checkBurst(input string tag, input int acc, input int n);
        checkOutput({tag, "_count_l1"}, q1.size(), n);
        checkOutput({tag, "_count_l3"}, q3.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < q1.size()) begin
                checkOutput($sformatf("%s_l1_cyc%0d", tag, i), q1[i].cyc, acc + 1 + i);
                checkOutput($sformatf("%s_l1_data%0d", tag, i), q1[i].data, exp_beats[i]);
            end
            if (i < q3.size()) begin
                checkOutput($sformatf("%s_l3_cyc%0d", tag, i), q3[i].cyc, acc + 3 + i);
                checkOutput($sformatf("%s_l3_data%0d", tag, i), q3[i].data, exp_beats[i]);
            end
        end
    endtask

    task automatic clear_q();
        q1.delete();
        q3.delete();
    endtask

    initial begin
        int acc;
        int rel;

        // Reset values and the waitrequest equation while held in reset.
        bus_idle();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst_rdv_l1", rdv1, 0);
        checkOutput("rst_rdv_l3", rdv3, 0);
        checkOutput("rst_rdata_l1", rd1, 0);
        checkOutput("rst_err_l1", err1, 0);
        checkOutput("rst_err_l3", err3, 0);
`ifndef DDR3_MEM_MODEL_RANDOM_WAIT_EN
        checkOutput("rst_wait", wr1, 0);
`endif
        ddr_read  = 1'b1;
        ddr_write = 1'b1;
        #2;
        checkOutput("rst_wait_both", wr1, 1);
        bus_idle();
        @(posedge clk);
        #1;
        checkOutput("rst_err_hold", err1, 0);
        reset_n = 1'b1;

        // Single write then single read of address 5.
        applyStimulus(1'b0, 1'b1, 16'd5, 16'sh7FFF, 4'd1, acc);
        bus_idle();
        clear_q();
        applyStimulus(1'b1, 1'b0, 16'd5, 16'sh0000, 4'd1, acc);
        bus_idle();
`ifndef DDR3_MEM_MODEL_RANDOM_WAIT_EN
        @(negedge clk);
        checkOutput("single_rd_no_wait", wr1, 0);
`endif
        repeat (8) @(posedge clk);
        #1;
        exp_beats[0] = 32767;
        checkBurst("single", acc, 1);

        // Write burst of four at address 10, then read it back as a burst.
        applyStimulus(1'b0, 1'b1, 16'd10, -16'sd1, 4'd4, acc);
        applyStimulus(1'b0, 1'b1, 16'd0, -16'sd2, 4'd0, acc);
        applyStimulus(1'b0, 1'b1, 16'd0, -16'sd3, 4'd0, acc);
        applyStimulus(1'b0, 1'b1, 16'd0, -16'sd4, 4'd0, acc);
        bus_idle();
        clear_q();
        applyStimulus(1'b1, 1'b0, 16'd10, 16'sh0000, 4'd4, acc);
        bus_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("burst_wait%0d", i), wr1, 1);
        end
`ifndef DDR3_MEM_MODEL_RANDOM_WAIT_EN
        @(negedge clk);
        checkOutput("burst_wait_end", wr1, 0);
`endif
        repeat (10) @(posedge clk);
        #1;
        exp_beats[0] = -1;
        exp_beats[1] = -2;
        exp_beats[2] = -3;
        exp_beats[3] = -4;
        checkBurst("burst4", acc, 4);
        checkOutput("burst_err_clean", err1, 0);

        // Read and write together: blocked, flagged, memory untouched.
        ddr_read       = 1'b1;
        ddr_write      = 1'b1;
        ddr_addr       = 16'd0;
        ddr_writedata  = 16'sd1234;
        ddr_burstcount = 4'd1;
        @(negedge clk);
        checkOutput("both_wait", wr1, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("both_err_l1", err1, 1);
        checkOutput("both_err_l3", err3, 1);
        bus_idle();
        @(posedge clk);
        #1;
        clear_q();
        applyStimulus(1'b1, 1'b0, 16'd0, 16'sh0000, 4'd1, acc);
        bus_idle();
        repeat (8) @(posedge clk);
        #1;
        exp_beats[0] = 0;
        checkBurst("both_mem", acc, 1);

        // Read burst running past the end of memory.
        do_reset();
        checkOutput("err_cleared", err1, 0);
        applyStimulus(1'b0, 1'b1, 16'd510, 16'sd100, 4'd2, acc);
        applyStimulus(1'b0, 1'b1, 16'd0, -16'sd200, 4'd0, acc);
        bus_idle();
        checkOutput("edge_wr_err", err1, 0);
        clear_q();
        applyStimulus(1'b1, 1'b0, 16'd510, 16'sh0000, 4'd4, acc);
        bus_idle();
        repeat (10) @(posedge clk);
        #1;
        exp_beats[0] = 100;
        exp_beats[1] = -200;
        exp_beats[2] = 0;
        exp_beats[3] = 0;
        checkBurst("oor_rd", acc, 4);
        checkOutput("oor_rd_err_l1", err1, 1);
        checkOutput("oor_rd_err_l3", err3, 1);

        // Out-of-range write is dropped (must not alias onto address 0).
        do_reset();
        applyStimulus(1'b0, 1'b1, 16'd512, 16'sh5555, 4'd1, acc);
        bus_idle();
        @(negedge clk);
        checkOutput("oor_wr_err", err1, 1);
        @(posedge clk);
        #1;
        clear_q();
        applyStimulus(1'b1, 1'b0, 16'd0, 16'sh0000, 4'd1, acc);
        bus_idle();
        repeat (8) @(posedge clk);
        #1;
        exp_beats[0] = 0;
        checkBurst("oor_wr_drop", acc, 1);

        // Reset one cycle into an 8-beat read burst.
        do_reset();
        clear_q();
        applyStimulus(1'b1, 1'b0, 16'd10, 16'sh0000, 4'd8, acc);
        bus_idle();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
`ifndef DDR3_MEM_MODEL_RANDOM_WAIT_EN
        @(negedge clk);
        checkOutput("rst_abort_wait", wr1, 0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rel = cyc;
        applyStimulus(1'b1, 1'b0, 16'd5, 16'sh0000, 4'd1, acc);
        bus_idle();
`ifndef DDR3_MEM_MODEL_RANDOM_WAIT_EN
        checkOutput("rst_reaccept", acc, rel + 1);
`endif
        repeat (8) @(posedge clk);
        #1;
        exp_beats[0] = 32767;
        checkBurst("rst_abort", acc, 1);

`ifdef DDR3_MEM_MODEL_RANDOM_WAIT_EN
        // Random stalls: 200 writes then read everything back in order.
        do_reset();
        stall_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            rand_data[i] = longint'($signed(16'($urandom)));
            applyStimulus(1'b0, 1'b1, 16'(100 + i), 16'(rand_data[i]), 4'd1, acc);
        end
        bus_idle();
        clear_q();
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b1, 1'b0, 16'(100 + i), 16'sh0000, 4'd1, acc);
        end
        bus_idle();
        repeat (10) @(posedge clk);
        #1;
        checkOutput("rand_count_l1", q1.size(), 200);
        checkOutput("rand_count_l3", q3.size(), 200);
        for (int i = 0; i < 200; i++) begin
            if (i < q1.size()) checkOutput($sformatf("rand_l1_%0d", i), q1[i].data, rand_data[i]);
            if (i < q3.size()) checkOutput($sformatf("rand_l3_%0d", i), q3[i].data, rand_data[i]);
        end
        checkOutput("rand_stall_seen", longint'(stall_cnt > 0), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
